// File: rtl/chaos_key_serializer.sv
// rtl/chaos_key_serializer.sv - captures a key word and shifts it out over a ser_clk/ser_data/ser_latch link.
// Define CHAOS_KEY_PARITY_EN to append an even-parity bit after the last key bit.
module chaos_key_serializer #(
   parameter int KEY_W     = 32,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [KEY_W-1:0] key_in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             ser_clk,
   output logic             ser_data,
   output logic             ser_latch
);

`ifdef CHAOS_KEY_PARITY_EN
   localparam int N = KEY_W + 1;
`else
   localparam int N = KEY_W;
`endif
   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int BIT_W = $clog2(KEY_W + 1) + 1;

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LATCH, DONE} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [N-1:0]     shreg;
   logic [N-1:0]     load_word;
   logic             div_end;
   logic             cur_bit;

   assign div_end = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign cur_bit = (MSB_FIRST != 0) ? shreg[N-1] : shreg[0];

   // The parity bit always travels last, so it sits at the opposite end from the first bit.
`ifdef CHAOS_KEY_PARITY_EN
   logic parity;
   assign parity    = ^key_in;
   assign load_word = (MSB_FIRST != 0) ? {key_in, parity} : {parity, key_in};
`else
   assign load_word = key_in;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETUP;
         SETUP:   if (div_end) state_nxt = HIGH;
         HIGH:    if (div_end) state_nxt = (bit_cnt == '0) ? LATCH : SETUP;
         LATCH:   if (div_end) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      ser_clk   = 1'b0;
      ser_data  = 1'b0;
      ser_latch = 1'b0;
      case (state)
         SETUP: begin
            busy     = 1'b1;
            ser_data = cur_bit;
         end
         HIGH: begin
            busy     = 1'b1;
            ser_clk  = 1'b1;
            ser_data = cur_bit;
         end
         LATCH: begin
            busy      = 1'b1;
            ser_latch = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Shifting only at the end of HIGH keeps ser_data stable for a full SETUP and HIGH phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
      end else begin
         if (state == IDLE || state_nxt != state) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (state == IDLE && start) begin
            shreg   <= load_word;
            bit_cnt <= BIT_W'(N - 1);
         end else if (state == HIGH && div_end && bit_cnt != '0) begin
            shreg   <= (MSB_FIRST != 0) ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
            bit_cnt <= bit_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_chaos_key_serializer.sv
// tb/tb_chaos_key_serializer.sv - directed vector bench for chaos_key_serializer.
module tb_chaos_key_serializer;

`ifdef CHAOS_KEY_PARITY_EN
   localparam int N = 33;
`else
   localparam int N = 32;
`endif

   typedef struct {
      logic [31:0] key;
      logic [31:0] rev;
      logic        par;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_a, start_b;
   logic [31:0] key_in;
   logic        a_busy, a_done, a_ser_clk, a_ser_data, a_ser_latch;
   logic        b_busy, b_done, b_ser_clk, b_ser_data, b_ser_latch;

   int pass_cnt  = 0;
   int total_cnt = 0;

   chaos_key_serializer #(.KEY_W(32), .CLK_DIV(4), .MSB_FIRST(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .key_in(key_in), .start(start_a),
      .busy(a_busy), .done(a_done), .ser_clk(a_ser_clk),
      .ser_data(a_ser_data), .ser_latch(a_ser_latch)
   );

   chaos_key_serializer #(.KEY_W(32), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .key_in(key_in), .start(start_b),
      .busy(b_busy), .done(b_done), .ser_clk(b_ser_clk),
      .ser_data(b_ser_data), .ser_latch(b_ser_latch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // {busy, done, ser_clk, ser_data, ser_latch}
   function automatic logic [4:0] outs(input bit sel);
      return sel ? {b_busy, b_done, b_ser_clk, b_ser_data, b_ser_latch}
                 : {a_busy, a_done, a_ser_clk, a_ser_data, a_ser_latch};
   endfunction

   // Cycle k is the clk period beginning k edges after the start edge.
   task automatic measure(input bit sel, input int change_at, output logic [63:0] acc,
                          output int edges, output int latch_len, output int busy_len,
                          output int done_at);
      logic       prev_clk;
      logic [4:0] o;
      prev_clk = 1'b0;
      acc = '0; edges = 0; latch_len = 0; busy_len = 0; done_at = -1;
      for (int k = 0; k < 700; k++) begin
         @(negedge clk);
         if (k == change_at) key_in = '0;
         o = outs(sel);
         if (o[2] && !prev_clk) begin
            acc = {acc[62:0], o[1]};
            edges++;
         end
         prev_clk = o[2];
         if (o[0]) latch_len++;
         if (o[4]) busy_len++;
         if (o[3]) begin
            done_at = k;
            break;
         end
      end
   endtask

   task automatic run_frame(input bit sel, input logic [31:0] key, input bit hold,
                            input int change_at, output logic [63:0] acc, output int edges,
                            output int latch_len, output int busy_len, output int done_at);
      @(posedge clk);
      #1;
      key_in = key;
      if (sel) start_b = 1'b1;
      else start_a = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) begin
         start_a = 1'b0;
         start_b = 1'b0;
      end
      measure(sel, change_at, acc, edges, latch_len, busy_len, done_at);
   endtask

   task automatic check_frame(input string tag, input logic [31:0] exp_word, input logic exp_par,
                              input int div, input logic [63:0] acc, input int edges,
                              input int latch_len, input int busy_len, input int done_at);
      logic [31:0] key_bits;
`ifdef CHAOS_KEY_PARITY_EN
      key_bits = acc[32:1];
      chk({tag, " parity"}, acc[0], exp_par);
`else
      key_bits = acc[31:0];
`endif
      chk({tag, " edges"}, edges, N);
      chk({tag, " word"}, key_bits, exp_word);
      chk({tag, " latch_len"}, latch_len, div);
      chk({tag, " done_at"}, done_at, (2 * N + 1) * div);
      chk({tag, " busy_len"}, busy_len, (2 * N + 1) * div);
   endtask

   initial begin
      vec_t        vecs[6];
      logic [63:0] acc;
      int          edges, latch_len, busy_len, done_at, rises;
      logic        prev;
      logic [4:0]  o;

      vecs[0] = '{key: 32'hA5A5_0F01, rev: 32'h80F0_A5A5, par: 1'b1};
      vecs[1] = '{key: 32'h0000_0001, rev: 32'h8000_0000, par: 1'b1};
      vecs[2] = '{key: 32'h0000_0007, rev: 32'hE000_0000, par: 1'b1};
      vecs[3] = '{key: 32'h0000_0003, rev: 32'hC000_0000, par: 1'b0};
      vecs[4] = '{key: 32'hFFFF_FFFF, rev: 32'hFFFF_FFFF, par: 1'b0};
      vecs[5] = '{key: 32'h1234_5678, rev: 32'h1E6A_2C48, par: 1'b1};

      // reset with start asserted
      reset_n = 1'b0;
      start_a = 1'b1;
      start_b = 1'b1;
      key_in  = 32'hA5A5_0F01;
      #23;
      chk("t1 reset outs a", outs(0), 5'b0);
      chk("t1 reset outs b", outs(1), 5'b0);
      start_a = 1'b0;
      start_b = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t1 idle outs a", outs(0), 5'b0);
      chk("t1 idle outs b", outs(1), 5'b0);

      for (int i = 0; i < 6; i++) begin
         run_frame(0, vecs[i].key, 0, -1, acc, edges, latch_len, busy_len, done_at);
         check_frame($sformatf("a%0d", i), vecs[i].key, vecs[i].par, 4,
                     acc, edges, latch_len, busy_len, done_at);
         @(negedge clk);
         chk($sformatf("a%0d done width", i), outs(0), 5'b0);
         run_frame(1, vecs[i].key, 0, -1, acc, edges, latch_len, busy_len, done_at);
         check_frame($sformatf("b%0d", i), vecs[i].rev, vecs[i].par, 1,
                     acc, edges, latch_len, busy_len, done_at);
         @(negedge clk);
         chk($sformatf("b%0d done width", i), outs(1), 5'b0);
      end

      // start held high, key changed mid-frame
      run_frame(0, 32'hA5A5_0F01, 1, 20, acc, edges, latch_len, busy_len, done_at);
      check_frame("t3 f1", 32'hA5A5_0F01, 1'b1, 4, acc, edges, latch_len, busy_len, done_at);
      @(negedge clk);
      o = outs(0);
      chk("t3 idle gap", o, 5'b0);
      measure(0, -1, acc, edges, latch_len, busy_len, done_at);
      start_a = 1'b0;
      check_frame("t3 f2", 32'h0, 1'b0, 4, acc, edges, latch_len, busy_len, done_at);
      repeat (4) @(negedge clk);
      chk("t3 no third frame", outs(0), 5'b0);

      // reset during the HIGH phase of bit 10
      @(posedge clk);
      #1;
      key_in  = 32'hFFFF_FFFF;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      rises = 0;
      prev  = 1'b0;
      for (int k = 0; k < 600 && rises < 11; k++) begin
         @(negedge clk);
         if (a_ser_clk && !prev) rises++;
         prev = a_ser_clk;
      end
      chk("t4 reached bit 10", rises, 11);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t4 async clear", outs(0), 5'b0);
      rises = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (a_ser_latch || a_done) rises++;
      end
      chk("t4 no latch/done in reset", rises, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("t4 idle after release", outs(0), 5'b0);
      run_frame(0, 32'h0000_0001, 0, -1, acc, edges, latch_len, busy_len, done_at);
      check_frame("t4 post", 32'h0000_0001, 1'b1, 4, acc, edges, latch_len, busy_len, done_at);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
